// File: rtl/atom_cfg_loader_if.sv
// Configuration stream bundle for atom_cfg_loader: valid/ready beats
// carrying a 3-bit word index, a WIDTH-bit payload and an end-of-transaction flag.
interface atom_cfg_loader_if #(
    parameter int WIDTH = 32
);
    logic             cfg_valid;
    logic             cfg_ready;
    logic [2:0]       cfg_addr;
    logic [WIDTH-1:0] cfg_data;
    logic             cfg_last;

    modport master (
        output cfg_valid, cfg_addr, cfg_data, cfg_last,
        input  cfg_ready
    );

    modport slave (
        input  cfg_valid, cfg_addr, cfg_data, cfg_last,
        output cfg_ready
    );
endinterface

// File: rtl/atom_cfg_loader.sv
// atom_cfg_loader: assembles configuration beats into shadow registers and
// commits the complete set to the live atom configuration only when the
// atom pipeline reports a packet boundary, so an atom never sees a
// half-updated configuration inside a packet.
// Optional feature macro: ATOM_CFG_READBACK_EN adds a registered readback
// port (rd_addr_i / rd_shadow_i / rd_data_o) for live or shadow words.
module atom_cfg_loader #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    atom_cfg_loader_if.slave     cfg,
    input  logic                 pipe_idle_i,
    input  logic                 err_clr_i,
    output logic [WIDTH-1:0]     cons_1_o,
    output logic [WIDTH-1:0]     cons_2_o,
    output logic [WIDTH-1:0]     cons_3_o,
    output logic [WIDTH-1:0]     cons_4_o,
    output logic [WIDTH-1:0]     cons_5_o,
    output logic                 sel_1_o,
    output logic [1:0]           sel_2_o,
    output logic                 sel_3_o,
    output logic [1:0]           sel_4_o,
    output logic                 sel_5_o,
    output logic [1:0]           sel_6_o,
    output logic [1:0]           sel_7_o,
    output logic [1:0]           sel_8_o,
    output logic [1:0]           rel_opcode_o,
`ifdef ATOM_CFG_READBACK_EN
    input  logic [2:0]           rd_addr_i,
    input  logic                 rd_shadow_i,
    output logic [WIDTH-1:0]     rd_data_o,
`endif
    output logic [CNT_W-1:0]     commit_count_o,
    output logic                 err_o
);

    // Select word: 9 fields packed into bits [14:0]; everything above is reserved.
    localparam int SEL_W = 15;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LOAD    = 2'd1,
        PENDING = 2'd2
    } state_e;

    state_e                   state_q, state_d;
    logic [4:0][WIDTH-1:0]    sh_cons_q, sh_cons_d;
    logic [SEL_W-1:0]         sh_sel_q, sh_sel_d;
    logic [4:0][WIDTH-1:0]    live_cons_q, live_cons_d;
    logic [SEL_W-1:0]         live_sel_q, live_sel_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic                     err_q, err_d;

    logic accept;
    logic beat_bad;
    logic commit;

    // Ready drops while a commit is outstanding and during reset.
    assign cfg.cfg_ready = (state_q != PENDING) && !rst;
    assign accept        = cfg.cfg_valid && cfg.cfg_ready;
    assign commit        = (state_q == PENDING) && pipe_idle_i;

    // Unmapped addresses and select words with reserved bits set are rejected.
    always_comb begin
        beat_bad = 1'b0;
        if (cfg.cfg_addr >= 3'd6)
            beat_bad = 1'b1;
        else if (cfg.cfg_addr == 3'd5 && |cfg.cfg_data[WIDTH-1:SEL_W])
            beat_bad = 1'b1;
    end

    // Transaction FSM: IDLE -> LOAD -> PENDING -> IDLE; a rejected last beat still ends it.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = cfg.cfg_last ? PENDING : LOAD;
            LOAD:    if (accept && cfg.cfg_last) state_d = PENDING;
            PENDING: if (pipe_idle_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Shadow writes, atomic shadow-to-live copy, commit counter and sticky error.
    always_comb begin
        sh_cons_d   = sh_cons_q;
        sh_sel_d    = sh_sel_q;
        live_cons_d = live_cons_q;
        live_sel_d  = live_sel_q;
        cnt_d       = cnt_q;
        err_d       = err_q;

        if (accept && !beat_bad) begin
            if (cfg.cfg_addr == 3'd5)
                sh_sel_d = cfg.cfg_data[SEL_W-1:0];
            else
                sh_cons_d[cfg.cfg_addr] = cfg.cfg_data;
        end

        if (commit) begin
            live_cons_d = sh_cons_q;
            live_sel_d  = sh_sel_q;
            cnt_d       = cnt_q + 1'b1;
        end

        // A new error in the same cycle as a clear leaves the flag set.
        if (accept && beat_bad)
            err_d = 1'b1;
        else if (err_clr_i)
            err_d = 1'b0;
    end

    // State and configuration registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            sh_cons_q   <= '0;
            sh_sel_q    <= '0;
            live_cons_q <= '0;
            live_sel_q  <= '0;
            cnt_q       <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            sh_cons_q   <= sh_cons_d;
            sh_sel_q    <= sh_sel_d;
            live_cons_q <= live_cons_d;
            live_sel_q  <= live_sel_d;
            cnt_q       <= cnt_d;
            err_q       <= err_d;
        end
    end

    assign cons_1_o       = live_cons_q[0];
    assign cons_2_o       = live_cons_q[1];
    assign cons_3_o       = live_cons_q[2];
    assign cons_4_o       = live_cons_q[3];
    assign cons_5_o       = live_cons_q[4];
    assign sel_1_o        = live_sel_q[0];
    assign sel_2_o        = live_sel_q[2:1];
    assign sel_3_o        = live_sel_q[3];
    assign sel_4_o        = live_sel_q[5:4];
    assign sel_5_o        = live_sel_q[6];
    assign sel_6_o        = live_sel_q[8:7];
    assign sel_7_o        = live_sel_q[10:9];
    assign sel_8_o        = live_sel_q[12:11];
    assign rel_opcode_o   = live_sel_q[14:13];
    assign commit_count_o = cnt_q;
    assign err_o          = err_q;

`ifdef ATOM_CFG_READBACK_EN
    logic [WIDTH-1:0] rd_data_q, rd_data_d;

    // Readback mux: live or shadow word, reserved select bits read as zero.
    always_comb begin
        rd_data_d = '0;
        if (rd_addr_i <= 3'd4)
            rd_data_d = rd_shadow_i ? sh_cons_q[rd_addr_i] : live_cons_q[rd_addr_i];
        else if (rd_addr_i == 3'd5)
            rd_data_d[SEL_W-1:0] = rd_shadow_i ? sh_sel_q : live_sel_q;
    end

    // One-cycle registered readback.
    always_ff @(posedge clk) begin
        if (rst) rd_data_q <= '0;
        else     rd_data_q <= rd_data_d;
    end

    assign rd_data_o = rd_data_q;
`endif

endmodule

// File: doc/atom_cfg_loader.md
# atom_cfg_loader

Control-plane writer for the stateful packet-transaction atoms. It accepts configuration words over a valid/ready stream and assembles them into shadow registers: the five constants, the eight mux selects and the relational opcode. At a packet boundary it commits the whole set atomically to the live outputs that drive an atom's `cons_*`, `sel_*` and `rel_opcode` inputs. An atom therefore never sees a half-updated configuration within a packet.

## Interface
Parameters:
- `WIDTH`, 32: width of the constants and of `cfg_data`.
- `CNT_W`, 8: width of `commit_count`.

Ports:
- Clock and reset: one clock; reset is synchronous and active-high.
  - `clk` in 1: clock.
  - `rst` in 1: synchronous, active-high reset.
- Configuration stream:
  - `cfg_valid` in 1: configuration beat valid.
  - `cfg_ready` out 1: loader can accept a beat.
  - `cfg_addr` in 3: word index.
  - `cfg_data` in WIDTH: word payload.
  - `cfg_last` in 1: final beat of the transaction.
- Pipeline and error control:
  - `pipe_idle` in 1: atom pipeline is at a packet boundary; commit permitted.
  - `err_clr` in 1: clears `err`.
- Live configuration:
  - `cons_1`..`cons_5` out WIDTH: live constants.
  - `sel_1`, `sel_3`, `sel_5` out 1: live 2-way selects.
  - `sel_2`, `sel_4`, `sel_6`, `sel_7`, `sel_8` out 2: live 3-way selects.
  - `rel_opcode` out 2: live relational opcode.
- Status:
  - `commit_count` out CNT_W: number of commits, wrapping.
  - `err` out 1: sticky error flag.

## Operation
- Beat acceptance: a beat is accepted on a rising edge with `cfg_valid && cfg_ready`. `cfg_ready = (state != PENDING) && !rst`.
- Address map, applied to shadow registers:
  - `cfg_addr` 0..4 → constants 1..5.
  - `cfg_addr` 5 → select word: `sel_1`[0], `sel_2`[2:1], `sel_3`[3], `sel_4`[5:4], `sel_5`[6], `sel_6`[8:7], `sel_7`[10:9], `sel_8`[12:11], `rel_opcode`[14:13].
- Rejected beats: address 6 or 7, or a select word with any of bits [WIDTH-1:15] set. The beat is still consumed (handshake completes), the shadow is unchanged, and `err` is set.
- Shadow persistence: shadow words not written in a transaction keep their prior value. Partial updates are legal.
- State machine:
  - IDLE: no beats since the last commit. An accepted beat goes to LOAD, or to PENDING if `cfg_last`.
  - LOAD: an accepted beat with `cfg_last` goes to PENDING. Otherwise stay in LOAD.
  - PENDING: `cfg_ready=0`. On an edge with `pipe_idle=1`, copy all shadow to live, increment `commit_count`, and go to IDLE. Otherwise stay in PENDING.
- `cfg_last` on a rejected beat still ends the transaction; valid shadow contents commit.
- `commit_count`: wraps `2^CNT_W-1` → 0.
- `err`: sticky. When set and `err_clr` occur in the same cycle, set wins.
- Reset: all shadow and live registers, `commit_count` and `err` go to 0; state goes to IDLE. Reset in LOAD or PENDING discards the pending transaction.

## Timing
- Reset values: every output is 0, including `cfg_ready` while `rst=1`. `cfg_ready` is 1 in the first cycle after `rst` deasserts.
- Commit latency: last beat accepted at edge N → PENDING after N. With `pipe_idle=1` at edge N+1, live outputs and `commit_count` update after edge N+1. The minimum is one cycle from last beat to live.
- `cfg_ready` returns to 1 in the cycle after the commit edge.
- Live outputs are registered and change only on commit edges or reset.
- Back-to-back transactions: the first beat of the next transaction can be accepted in the cycle after the commit edge.

## Configuration
- `ATOM_CFG_READBACK_EN`
  - Defined: adds ports `rd_addr` in 3, `rd_shadow` in 1 and `rd_data` out WIDTH.
  - `rd_data` is registered with one-cycle latency. It returns the live word at `rd_addr`, or the shadow word when `rd_shadow=1`.
  - Addresses 0..5 use the write map, with the select word's reserved bits returned as 0. Addresses 6..7 return 0.
  - Reset value of `rd_data` is 0.
  - Undefined: these ports are absent and no readback logic is built.

## Test plan
- Full load: write addr 0..4 = 1,2,3,4,5 and addr 5 = 0x7FFF with `cfg_last`, `pipe_idle=1` → one cycle later `cons_1..5` = 1..5, all selects = max values, `rel_opcode=3`, `commit_count=1`.
- Commit hold: `pipe_idle=0` for 10 cycles after the last beat → live outputs unchanged and `cfg_ready=0` throughout. Raise `pipe_idle` → commit on the next edge, then `cfg_ready=1`.
- Partial update: after the full load, write only addr 2 = 0xDEAD with `cfg_last` → `cons_3=0xDEAD`, other outputs keep the full-load values.
- Errors:
  - Write addr 6 → `err=1`, shadow unchanged.
  - Select word 0x0001_8000 → `err=1`, select word rejected.
  - `err_clr` coinciding with a new error → `err` stays 1.
- Reset mid-transaction: reset asserted in LOAD and again in PENDING → all outputs 0, state IDLE, no commit afterwards until a new transaction.
- Wrap: 256 commits → `commit_count` returns to 0.
